zion_basic_circuit_lib_pipe_dff: RTL and testbench



---
 rtl/zion_basic_circuit_lib_pipe_dff.sv | 146 ++++++++++++++
 tb/tb_zion_basic_circuit_lib_pipe_dff.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/zion_basic_circuit_lib_pipe_dff.sv
// Multi-stage valid/ready register pipeline with bubble collapsing and an
// optional one-entry input skid buffer that makes oReady a pure flop output.
module zion_basic_circuit_lib_pipe_dff #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INI_DATA = '0,
  parameter int               SKID     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iFlush,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic [WIDTH-1:0]           iDat,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [WIDTH-1:0]           oDat,
  output logic [$clog2(DEPTH+2)-1:0] oCnt
);

  localparam int CNT_W = $clog2(DEPTH + 2);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 1) begin : g_chk_depth
    $error("zion_basic_circuit_lib_pipe_dff: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_chk_width
    $error("zion_basic_circuit_lib_pipe_dff: WIDTH must be >= 1");
  end
  if (SKID != 0 && SKID != 1) begin : g_chk_skid
    $error("zion_basic_circuit_lib_pipe_dff: SKID must be 0 or 1");
  end

  // Stage k holds v_q[k]/d_q[k]; index DEPTH-1 is the output stage.
  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_xfer;

  // Stage k may load when it, or any stage downstream of it, is empty, or
  // when the output is being accepted. Written as a flat reduction so each
  // bit depends only on flops and iReady.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = iReady;
      for (int j = k; j < DEPTH; j++) begin
        if (!v_q[j]) adv[k] = 1'b1;
      end
    end
  end

  // With a skid buffer ready comes straight from a flop; without it, ready
  // is the combinational advance of stage 0.
  assign oReady  = (SKID != 0) ? !skid_v_q : adv[0];
  assign in_xfer = iValid && oReady;

  // Next-state for stages, skid entry and occupancy count.
  always_comb begin
    // NOTE: every variable gets a default before any branch so the
    // combinational block never implies a latch.
    v_d      = v_q;
    d_d      = d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    src_v    = '0;
    src_d    = d_q;

    // Stage 0 drains the skid entry first so ordering is preserved.
    if (SKID != 0 && skid_v_q) begin
      src_v[0] = 1'b1;
      src_d[0] = skid_d_q;
    end else begin
      src_v[0] = in_xfer;
      src_d[0] = iDat;
    end
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = d_q[k-1];
    end

    // Advancing stages take the source valid; data moves only with a
    // valid source so an emptied stage keeps its last value.
    for (int k = 0; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) d_d[k] = src_d[k];
      end
    end

    if (SKID != 0) begin
      if (skid_v_q && adv[0]) skid_v_d = 1'b0;
      if (in_xfer && !adv[0]) begin
        skid_v_d = 1'b1;
        skid_d_d = iDat;
      end
    end

    // Flush drops every entry (including one arriving this cycle) but
    // leaves data registers untouched.
    if (iFlush) begin
      v_d      = '0;
      skid_v_d = 1'b0;
      d_d      = d_q;
      skid_d_d = skid_d_q;
    end

    cnt_d = CNT_W'(skid_v_d);
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d = cnt_d + CNT_W'(v_d[k]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset here (unlike a typical storage array)
      // because INI_DATA is visible on oDat while the pipe is empty.
      v_q      <= '0;
      skid_v_q <= 1'b0;
      skid_d_q <= INI_DATA;
      cnt_q    <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= INI_DATA;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      v_q      <= v_d;
      d_q      <= d_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign oValid = v_q[DEPTH-1];
  assign oDat   = d_q[DEPTH-1];
  assign oCnt   = cnt_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_pipe_dff.sv
// Scoreboard bench: dut1 is DEPTH=3/SKID=1, dut2 is DEPTH=1/SKID=0.
module tb_zion_basic_circuit_lib_pipe_dff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // dut1 signals
  logic       rst1, iFlush1, iValid1, oReady1, oValid1, iReady1;
  logic [7:0] iDat1, oDat1;
  logic [2:0] oCnt1;
  // dut2 signals
  logic       rst2, iFlush2, iValid2, oReady2, oValid2, iReady2;
  logic [7:0] iDat2, oDat2;
  logic [1:0] oCnt2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  zion_basic_circuit_lib_pipe_dff #(
    .WIDTH(8), .DEPTH(3), .INI_DATA(8'hA5), .SKID(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .iFlush(iFlush1), .iValid(iValid1),
    .oReady(oReady1), .iDat(iDat1), .oValid(oValid1), .iReady(iReady1),
    .oDat(oDat1), .oCnt(oCnt1)
  );

  zion_basic_circuit_lib_pipe_dff #(
    .WIDTH(8), .DEPTH(1), .INI_DATA(8'h3C), .SKID(0)
  ) dut2 (
    .clk(clk), .rst(rst2), .iFlush(iFlush2), .iValid(iValid2),
    .oReady(oReady2), .iDat(iDat2), .oValid(oValid2), .iReady(iReady2),
    .oDat(oDat2), .oCnt(oCnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for dut1: inputs stay stable from posedge+1 to the next
  // posedge, so at negedge we know exactly which transfers the edge makes.
  always @(negedge clk) begin
    if (mon_en) begin
      check("cnt1", 32'(oCnt1), q1.size());
      if (rst1) begin
        q1.delete();
      end else begin
        if (oValid1 && iReady1) begin
          check("out1_expected", 32'(oValid1), 32'(q1.size() != 0));
          if (q1.size() != 0) check("out1_data", 32'(oDat1), 32'(q1.pop_front()));
        end
        if (iFlush1) q1.delete();
        else if (iValid1 && oReady1) q1.push_back(iDat1);
      end
    end
  end

  // Scoreboard for dut2.
  always @(negedge clk) begin
    if (mon_en) begin
      check("cnt2", 32'(oCnt2), q2.size());
      if (rst2) begin
        q2.delete();
      end else begin
        if (oValid2 && iReady2) begin
          check("out2_expected", 32'(oValid2), 32'(q2.size() != 0));
          if (q2.size() != 0) check("out2_data", 32'(oDat2), 32'(q2.pop_front()));
        end
        if (iFlush2) q2.delete();
        else if (iValid2 && oReady2) q2.push_back(iDat2);
      end
    end
  end

  task automatic drain1();
    iValid1 = 1'b0;
    iReady1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q1.size() == 0 && !oValid1) break;
      step();
    end
    check("drain1_empty", q1.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nxt;
    bit         pat [7];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst1 = 1'b1; iFlush1 = 1'b0; iValid1 = 1'b0; iReady1 = 1'b0; iDat1 = '0;
    rst2 = 1'b1; iFlush2 = 1'b0; iValid2 = 1'b0; iReady2 = 1'b1; iDat2 = '0;
    step();
    step();
    rst1 = 1'b0;
    rst2 = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    check("rst_valid", 32'(oValid1), 0);
    check("rst_dat",   32'(oDat1),   32'hA5);
    check("rst_cnt",   32'(oCnt1),   0);
    check("rst_ready", 32'(oReady1), 1);
    check("rst2_ready", 32'(oReady2), 1);
    check("rst2_dat",   32'(oDat2),   32'h3C);

    // Streaming with iReady held high: 3-cycle latency, then one per cycle.
    iReady1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iValid1 = 1'b1;
      iDat1   = 8'(i + 1);
      step();
      if (i < 2)  check("stream_latency_low", 32'(oValid1), 0);
      if (i == 2) begin
        check("stream_first_valid", 32'(oValid1), 1);
        check("stream_first_dat",   32'(oDat1),   32'h01);
      end
      if (i >= 3) check("stream_cnt", 32'(oCnt1), 3);
    end
    drain1();

    // Back-pressure: three stages plus skid absorb four words.
    iReady1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iValid1 = 1'b1;
      iDat1   = 8'(i + 1);
      check("bp_ready_before_push", 32'(oReady1), 1);
      step();
    end
    check("bp_cnt_full",   32'(oCnt1),   4);
    check("bp_ready_full", 32'(oReady1), 0);
    iDat1 = 8'h05;
    step();
    check("bp_fifth_not_taken_cnt", 32'(oCnt1),   4);
    check("bp_still_full",          32'(oReady1), 0);
    iValid1 = 1'b0;
    iReady1 = 1'b1;
    step();
    check("bp_ready_returns", 32'(oReady1), 1);
    check("bp_next_dat",      32'(oDat1),   32'h02);
    drain1();

    // Bubble collapse: entries pack into the last two stages under stall.
    iReady1 = 1'b0;
    iValid1 = 1'b1; iDat1 = 8'h11; step();
    iValid1 = 1'b0; step(); step();
    iValid1 = 1'b1; iDat1 = 8'h22; step();
    iValid1 = 1'b0; step();
    check("bubble_cnt",    32'(oCnt1),    2);
    check("bubble_packed", 32'(dut1.v_q), 32'b110);
    check("bubble_head",   32'(oDat1),    32'h11);
    iReady1 = 1'b1;
    step();
    check("bubble_second_valid", 32'(oValid1), 1);
    check("bubble_second_dat",   32'(oDat1),   32'h22);
    step();
    check("bubble_done", 32'(oValid1), 0);
    drain1();

    // Flush with full stages and an input transfer on the flush cycle.
    iReady1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iValid1 = 1'b1;
      iDat1   = 8'(8'h31 + i);
      step();
    end
    check("flush_pre_cnt", 32'(oCnt1), 3);
    iValid1 = 1'b1; iDat1 = 8'h3F; iReady1 = 1'b1; iFlush1 = 1'b1;
    check("flush_input_accepted", 32'(oReady1), 1);
    step();
    iFlush1 = 1'b0; iValid1 = 1'b0;
    check("flush_valid", 32'(oValid1), 0);
    check("flush_cnt",   32'(oCnt1),   0);
    check("flush_ready", 32'(oReady1), 1);
    check("flush_dat_hold", 32'(oDat1), 32'h31);
    for (int i = 0; i < 5; i++) step();
    check("flush_no_output", 32'(oValid1), 0);

    // dut2: combinational ready with DEPTH=1 under toggling iReady.
    nxt = 8'h41;
    for (int i = 0; i < 7; i++) begin
      iValid2 = 1'b1;
      iDat2   = nxt;
      iReady2 = pat[i];
      #1;
      check("skid0_ready", 32'(oReady2), 32'((q2.size() == 0) || pat[i]));
      if (oReady2) nxt = nxt + 8'd1;
      step();
    end
    // Reset mid-stream.
    iValid2 = 1'b1; iDat2 = nxt; iReady2 = 1'b0; rst2 = 1'b1;
    step();
    rst2 = 1'b0; iValid2 = 1'b0; iReady2 = 1'b1;
    check("skid0_rst_cnt",   32'(oCnt2),   0);
    check("skid0_rst_dat",   32'(oDat2),   32'h3C);
    check("skid0_rst_valid", 32'(oValid2), 0);
    step();
    step();

    check("final_q1_empty", q1.size(), 0);
    check("final_q2_empty", q2.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
